// File: rtl/clksel_pkg.sv
// Shared definitions for the HS/LS clock-switch sequencer.
// Holds the state encoding, the divider codes and the host address map
// constants, plus a helper that folds the config divider into a switch code.
package clksel_pkg;

  typedef enum logic [1:0] {
    ST_HS     = 2'b00,
    ST_REQ_LS = 2'b01,
    ST_LS     = 2'b10,
    ST_REQ_HS = 2'b11
  } state_e;

  localparam logic [1:0] DIV1 = 2'b00;
  localparam logic [1:0] DIV2 = 2'b01;
  localparam logic [1:0] DIV4 = 2'b10;

  localparam logic [7:0] HOST_BANK = 8'hFF;
  localparam logic [7:0] IO_BANK   = 8'h00;
  localparam logic [7:0] IO_LO     = 8'hFC;
  localparam logic [7:0] IO_HI     = 8'hFE;

  // Config divider 00 = /1, 01 = /2, 1x = /4.
  function automatic logic [1:0] div_code(input logic [1:0] cfg);
    logic [1:0] code;
    code = DIV1;
    if (cfg[1])      code = DIV4;
    else if (cfg[0]) code = DIV2;
    return code;
  endfunction

endpackage : clksel_pkg

// File: rtl/clksel_host_decode.sv
// Combinational bus-cycle decode for the clock sequencer.
// Ports:
//   addr    : CPU address, bank in [23:16]
//   vda/vpa : valid data / program address strobes
//   valid_c : cycle carries a valid address
//   host_c  : address falls in host memory (bank FF) or host I/O (00:FC00-00:FEFF)
module clksel_host_decode
  import clksel_pkg::*;
(
  input  logic [23:0] addr,
  input  logic        vda,
  input  logic        vpa,
  output logic        valid_c,
  output logic        host_c
);

  logic [7:0] bank;
  logic [7:0] page;
  logic       unused_addr_c;

  always_comb begin
    bank          = addr[23:16];
    page          = addr[15:8];
    valid_c       = vda | vpa;
    host_c        = (bank == HOST_BANK) |
                    ((bank == IO_BANK) & (page >= IO_LO) & (page <= IO_HI));
    // Byte offset within a page never affects host classification.
    unused_addr_c = ^addr[7:0];
  end

endmodule : clksel_host_decode

// File: rtl/clksel_sequencer.sv
// Initiator side of the HS/LS clock-switch handshake.
// Forces LS clocking for host accesses, holds LS for HOLDOFF valid non-host
// cycles before asking for HS again, and flags a sticky error when the switch
// does not acknowledge a request within TIMEOUT cycles.
// Ports:
//   cpuclk_in, rst      : CPU output clock, async active-high reset
//   addr, vda, vpa      : 65816 bus cycle
//   force_ls, cfg_div   : stay-in-LS config, requested divider
//   hsclk_selected,
//   lsclk_selected      : switch feedback
//   hsclk_sel           : HS request to the switch
//   cpuclk_div_sel      : divider select (only updated while in LS)
//   rdy                 : CPU RDY
//   sw_err              : sticky handshake timeout
//   state_o             : current state for debug
// Build option: CLKSEL_RDY_STALL_EN drops rdy during REQ_LS/REQ_HS;
// without it rdy stays 1.
module clksel_sequencer
  import clksel_pkg::*;
#(
  parameter int unsigned HOLDOFF   = 8,
  parameter int unsigned HOLDOFF_W = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned TIMEOUT_W = 7
) (
  input  logic        cpuclk_in,
  input  logic        rst,
  input  logic [23:0] addr,
  input  logic        vda,
  input  logic        vpa,
  input  logic        force_ls,
  input  logic [1:0]  cfg_div,
  input  logic        hsclk_selected,
  input  logic        lsclk_selected,
  output logic        hsclk_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic        rdy,
  output logic        sw_err,
  output logic [1:0]  state_o
);

  localparam logic [HOLDOFF_W-1:0] HOLDOFF_RELOAD = HOLDOFF_W'(HOLDOFF);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT  = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX    = {TIMEOUT_W{1'b1}};

  state_e               state_q, state_d;
  logic                 hsclk_sel_q, hsclk_sel_d;
  logic [1:0]           div_sel_q, div_sel_d;
  logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic                 sw_err_q, sw_err_d;
  logic                 rdy_q, rdy_d;

  logic                 valid_c;
  logic                 host_c;
  logic                 host_hit_c;
  logic                 want_ls_c;
  logic                 ls_done_c;
  logic                 hs_done_c;
  logic [TIMEOUT_W-1:0] timeout_inc_c;

  clksel_host_decode u_decode (
    .addr    (addr),
    .vda     (vda),
    .vpa     (vpa),
    .valid_c (valid_c),
    .host_c  (host_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    hsclk_sel_d = hsclk_sel_q;
    div_sel_d   = div_sel_q;
    holdoff_d   = holdoff_q;
    timeout_d   = timeout_q;
    sw_err_d    = sw_err_q;

    host_hit_c    = valid_c & host_c;
    want_ls_c     = host_hit_c | force_ls;
    // Both or neither feedback bits set means the switch is still in flight.
    ls_done_c     = lsclk_selected & ~hsclk_selected;
    hs_done_c     = hsclk_selected & ~lsclk_selected;
    timeout_inc_c = (timeout_q == TIMEOUT_MAX) ? timeout_q
                                               : timeout_q + TIMEOUT_W'(1);

    case (state_q)
      ST_HS: begin
        if (want_ls_c) begin
          state_d     = ST_REQ_LS;
          hsclk_sel_d = 1'b0;
          holdoff_d   = HOLDOFF_RELOAD;
          timeout_d   = '0;
        end
      end

      ST_REQ_LS: begin
        if (ls_done_c) begin
          state_d = ST_LS;
        end else begin
          timeout_d = timeout_inc_c;
          if (timeout_inc_c == TIMEOUT_LIMIT) sw_err_d = 1'b1;
        end
      end

      ST_LS: begin
        // Divider only moves while running on the LS clock.
        div_sel_d = div_code(cfg_div);
        if (host_hit_c) begin
          holdoff_d = HOLDOFF_RELOAD;
        end else if (valid_c && (holdoff_q != '0)) begin
          holdoff_d = holdoff_q - HOLDOFF_W'(1);
        end
        if ((holdoff_q == '0) && !force_ls && !host_hit_c) begin
          state_d     = ST_REQ_HS;
          hsclk_sel_d = 1'b1;
          timeout_d   = '0;
        end
      end

      ST_REQ_HS: begin
        // A new LS demand wins over a completing HS switch.
        if (want_ls_c) begin
          state_d     = ST_REQ_LS;
          hsclk_sel_d = 1'b0;
          holdoff_d   = HOLDOFF_RELOAD;
          timeout_d   = '0;
        end else if (hs_done_c) begin
          state_d = ST_HS;
        end else begin
          timeout_d = timeout_inc_c;
          if (timeout_inc_c == TIMEOUT_LIMIT) sw_err_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_LS;
        hsclk_sel_d = 1'b0;
      end
    endcase

`ifdef CLKSEL_RDY_STALL_EN
    rdy_d = (state_d == ST_HS) || (state_d == ST_LS);
`else
    rdy_d = 1'b1;
`endif
  end

  // State and output registers; reset lands in LS to match the switch.
  always_ff @(posedge cpuclk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LS;
      hsclk_sel_q <= 1'b0;
      div_sel_q   <= DIV1;
      holdoff_q   <= HOLDOFF_RELOAD;
      timeout_q   <= '0;
      sw_err_q    <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      hsclk_sel_q <= hsclk_sel_d;
      div_sel_q   <= div_sel_d;
      holdoff_q   <= holdoff_d;
      timeout_q   <= timeout_d;
      sw_err_q    <= sw_err_d;
      rdy_q       <= rdy_d;
    end
  end

  assign hsclk_sel      = hsclk_sel_q;
  assign cpuclk_div_sel = div_sel_q;
  assign rdy            = rdy_q;
  assign sw_err         = sw_err_q;
  assign state_o        = state_q;

endmodule : clksel_sequencer

// File: tb/tb_clksel_sequencer.sv
// Self-checking bench for clksel_sequencer: directed bus/feedback sequences,
// expected outputs queued per driven cycle and compared after the edge.
`timescale 1ns/1ps
module tb_clksel_sequencer;

  localparam logic [1:0] S_HS  = 2'b00;
  localparam logic [1:0] S_RQL = 2'b01;
  localparam logic [1:0] S_LS  = 2'b10;
  localparam logic [1:0] S_RQH = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] addr;
  logic        vda;
  logic        vpa;
  logic        force_ls;
  logic [1:0]  cfg_div;
  logic        hsclk_selected;
  logic        lsclk_selected;
  logic        hsclk_sel;
  logic [1:0]  cpuclk_div_sel;
  logic        rdy;
  logic        sw_err;
  logic [1:0]  state_o;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       hs;
    logic [1:0] div;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [23:0] non_host [5] = '{24'h00FB00, 24'h01FD00, 24'h00FF00, 24'h012000, 24'h000000};

  always #5 clk = ~clk;

  clksel_sequencer dut (
    .cpuclk_in      (clk),
    .rst            (rst),
    .addr           (addr),
    .vda            (vda),
    .vpa            (vpa),
    .force_ls       (force_ls),
    .cfg_div        (cfg_div),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .rdy            (rdy),
    .sw_err         (sw_err),
    .state_o        (state_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic exp_rdy(input logic [1:0] st);
`ifdef CLKSEL_RDY_STALL_EN
    return (st == S_HS) || (st == S_LS);
`else
    return 1'b1;
`endif
  endfunction

  task automatic bus(input logic [23:0] a, input logic d, input logic p);
    addr = a;
    vda  = d;
    vpa  = p;
  endtask

  task automatic fb(input logic hs, input logic ls);
    hsclk_selected = hs;
    lsclk_selected = ls;
  endtask

  // Queue the expectation for the cycle being driven, clock it, then compare.
  task automatic step(input string tag, input logic [1:0] st, input logic hs,
                      input logic [1:0] div, input logic err);
    exp_t e;
    e.tag = tag; e.st = st; e.hs = hs; e.div = div; e.err = err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, "/state"}, 32'(state_o), 32'(e.st));
    check({e.tag, "/hsclk_sel"}, 32'(hsclk_sel), 32'(e.hs));
    check({e.tag, "/div_sel"}, 32'(cpuclk_div_sel), 32'(e.div));
    check({e.tag, "/sw_err"}, 32'(sw_err), 32'(e.err));
    check({e.tag, "/rdy"}, 32'(rdy), 32'(exp_rdy(e.st)));
  endtask

  initial begin
    rst = 1'b1;
    bus(24'h000000, 1'b0, 1'b0);
    force_ls = 1'b0;
    cfg_div  = 2'b00;
    fb(1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst/state", 32'(state_o), 32'(S_LS));
    check("rst/hsclk_sel", 32'(hsclk_sel), 32'(0));
    check("rst/div_sel", 32'(cpuclk_div_sel), 32'(0));
    check("rst/sw_err", 32'(sw_err), 32'(0));
    check("rst/rdy", 32'(rdy), 32'(1));
    @(negedge clk);
    rst = 1'b0;

    // Holdoff from reset: 8 non-host cycles in LS, then request HS.
    bus(24'h012000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step("p1_ls", S_LS, 1'b0, 2'b00, 1'b0);
    step("p1_req_hs", S_RQH, 1'b1, 2'b00, 1'b0);
    fb(1'b1, 1'b0);
    step("p1_hs", S_HS, 1'b1, 2'b00, 1'b0);

    // Host I/O access in HS, then holdoff reload by a host memory access.
    bus(24'h00FE40, 1'b1, 1'b0);
    step("p2_req_ls", S_RQL, 1'b0, 2'b00, 1'b0);
    bus(24'h012000, 1'b1, 1'b0);
    fb(1'b0, 1'b1);
    step("p2_ls", S_LS, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus(non_host[i], 1'b1, 1'b0);
      step("p2_pre", S_LS, 1'b0, 2'b00, 1'b0);
    end
    bus(24'hFF1000, 1'b0, 1'b1);
    step("p2_reload", S_LS, 1'b0, 2'b00, 1'b0);
    bus(24'h012000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("p2_post", S_LS, 1'b0, 2'b00, 1'b0);
    bus(24'h012000, 1'b0, 1'b0);
    step("p2_idle", S_LS, 1'b0, 2'b00, 1'b0);
    bus(24'h012000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("p2_post2", S_LS, 1'b0, 2'b00, 1'b0);
    step("p2_req_hs", S_RQH, 1'b1, 2'b00, 1'b0);

    // Host cycle coincident with HS completion goes back to REQ_LS.
    bus(24'h00FC10, 1'b1, 1'b0);
    fb(1'b1, 1'b0);
    step("p3_prio", S_RQL, 1'b0, 2'b00, 1'b0);

    // Stuck handshake: error on the 64th waiting cycle, sticky afterwards.
    bus(24'h012000, 1'b1, 1'b0);
    fb(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("p4_none", S_RQL, 1'b0, 2'b00, 1'b0);
    fb(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step("p4_both", S_RQL, 1'b0, 2'b00, 1'b0);
    fb(1'b1, 1'b0);
    for (int i = 0; i < 43; i++) step("p4_wait", S_RQL, 1'b0, 2'b00, 1'b0);
    step("p4_err_set", S_RQL, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) step("p4_err_hold", S_RQL, 1'b0, 2'b00, 1'b1);
    fb(1'b0, 1'b1);
    step("p4_ls", S_LS, 1'b0, 2'b00, 1'b1);

    // Divider follows cfg_div only in LS; force_ls pins LS.
    for (int i = 0; i < 8; i++) step("p5_ls", S_LS, 1'b0, 2'b00, 1'b1);
    step("p5_req_hs", S_RQH, 1'b1, 2'b00, 1'b1);
    fb(1'b1, 1'b0);
    step("p5_hs", S_HS, 1'b1, 2'b00, 1'b1);
    cfg_div = 2'b10;
    for (int i = 0; i < 3; i++) step("p5_hs_div", S_HS, 1'b1, 2'b00, 1'b1);
    bus(24'hFF0000, 1'b1, 1'b0);
    step("p5_req_ls", S_RQL, 1'b0, 2'b00, 1'b1);
    bus(24'h012000, 1'b1, 1'b0);
    fb(1'b0, 1'b1);
    step("p5_ls_entry", S_LS, 1'b0, 2'b00, 1'b1);
    step("p5_ls_div", S_LS, 1'b0, 2'b10, 1'b1);
    force_ls = 1'b1;
    for (int i = 0; i < 12; i++) step("p5_force", S_LS, 1'b0, 2'b10, 1'b1);
    force_ls = 1'b0;
    step("p5_release", S_RQH, 1'b1, 2'b10, 1'b1);

    // Asynchronous reset while a HS request is outstanding.
    #2;
    rst = 1'b1;
    #1;
    check("p6_rst/state", 32'(state_o), 32'(S_LS));
    check("p6_rst/hsclk_sel", 32'(hsclk_sel), 32'(0));
    check("p6_rst/div_sel", 32'(cpuclk_div_sel), 32'(0));
    check("p6_rst/sw_err", 32'(sw_err), 32'(0));
    check("p6_rst/rdy", 32'(rdy), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    step("p6_after", S_LS, 1'b0, 2'b10, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_clksel_sequencer
